posit_encode_pipe: RTL



---
 rtl/posit_encode_pipe_if.sv | 35 +++
 rtl/posit_encode_pipe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/posit_encode_pipe_if.sv
// rtl/posit_encode_pipe_if.sv - valid/ready stream bundle for the posit encoder
// Flag signals exist only when POSIT_ENCODE_FLAGS_EN is defined.
interface posit_encode_pipe_if #(
  parameter int NBITS = 32,
  parameter int SER_W = 38
);
  logic             in_valid;
  logic             in_ready;
  logic [SER_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_result;
`ifdef POSIT_ENCODE_FLAGS_EN
  logic             out_inexact;
  logic             out_saturated;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_result, out_inexact, out_saturated
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_result, out_inexact, out_saturated
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_result
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/posit_encode_pipe.sv
// rtl/posit_encode_pipe.sv - 3-stage serialized-to-posit32 (ES=2) encoder, RNE
// Optional POSIT_ENCODE_FLAGS_EN adds registered out_inexact/out_saturated.
module posit_encode_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int SER_W = 38
) (
  input  logic               clk,
  input  logic               rst_n,
  posit_encode_pipe_if.slave bus
);
  localparam logic signed [7:0] SAT_HI = 8'sd120;
  localparam logic signed [7:0] SAT_LO = -8'sd120;

  logic advance;
  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;

  // S1 decode: scale[7:2] read as signed is exactly floor(scale/4)
  logic signed [7:0] in_scale;
  logic              s1_sat_hi_d, s1_sat_lo_d;
  assign in_scale    = bus.in_data[SER_W-2 -: 8];
  assign s1_sat_hi_d = in_scale > SAT_HI;
  assign s1_sat_lo_d = in_scale < SAT_LO;

  logic          s1_valid_q, s1_sgn_q, s1_sat_hi_q, s1_sat_lo_q, s1_inf_q, s1_zero_q;
  logic [5:0]    s1_k_q;
  logic [ES-1:0] s1_e_q;
  logic [26:0]   s1_frac_q;

  // S2 assemble: regime word OR'd with {e, fraction} shifted past the regime
  logic [5:0]  k_neg, rlen;
  logic [63:0] reg_word, tail_word, word;
  always_comb begin
    k_neg = 6'd0 - s1_k_q;
    if (!s1_k_q[5]) begin
      reg_word = ~({64{1'b1}} >> (s1_k_q + 6'd1));
      rlen     = s1_k_q + 6'd2;
    end else begin
      reg_word = 64'h8000_0000_0000_0000 >> k_neg;
      rlen     = k_neg + 6'd1;
    end
    tail_word = {s1_e_q, s1_frac_q, 35'd0} >> rlen;
    word      = reg_word | tail_word;
  end

  logic        s2_valid_q, s2_sgn_q, s2_guard_q, s2_sticky_q;
  logic        s2_sat_hi_q, s2_sat_lo_q, s2_inf_q, s2_zero_q;
  logic [30:0] s2_body_q;

  // S3 round to nearest even, clamp into [minpos, maxpos], apply sign and specials
  logic        round_up, clamp_hi, clamp_lo;
  logic [31:0] rounded, mag, res_d;
  always_comb begin
    round_up = s2_guard_q & (s2_body_q[0] | s2_sticky_q);
    rounded  = {1'b0, s2_body_q} + {31'd0, round_up};
    clamp_hi = rounded[31];
    clamp_lo = (rounded == 32'd0);
    if (s2_sat_hi_q || clamp_hi)      mag = 32'h7FFF_FFFF;
    else if (s2_sat_lo_q || clamp_lo) mag = 32'h0000_0001;
    else                              mag = rounded;
    res_d = s2_sgn_q ? (32'd0 - mag) : mag;
    if (s2_inf_q)       res_d = 32'h8000_0000;
    else if (s2_zero_q) res_d = 32'h0000_0000;
  end

  logic             out_valid_q;
  logic [NBITS-1:0] out_result_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;

`ifdef POSIT_ENCODE_FLAGS_EN
  logic special, inexact_d, saturated_d, out_inexact_q, out_saturated_q;
  assign special     = s2_inf_q | s2_zero_q;
  assign inexact_d   = ~special & (s2_guard_q | s2_sticky_q | s2_sat_hi_q | s2_sat_lo_q);
  assign saturated_d = ~special & (s2_sat_hi_q | s2_sat_lo_q | clamp_hi | clamp_lo);
  assign bus.out_inexact   = out_inexact_q;
  assign bus.out_saturated = out_saturated_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inexact_q   <= 1'b0;
      out_saturated_q <= 1'b0;
    end else if (advance) begin
      out_inexact_q   <= inexact_d;
      out_saturated_q <= saturated_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sgn_q     <= 1'b0;
      s1_k_q       <= '0;
      s1_e_q       <= '0;
      s1_frac_q    <= '0;
      s1_sat_hi_q  <= 1'b0;
      s1_sat_lo_q  <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_sgn_q     <= 1'b0;
      s2_body_q    <= '0;
      s2_guard_q   <= 1'b0;
      s2_sticky_q  <= 1'b0;
      s2_sat_hi_q  <= 1'b0;
      s2_sat_lo_q  <= 1'b0;
      s2_inf_q     <= 1'b0;
      s2_zero_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else if (advance) begin
      s1_valid_q   <= bus.in_valid;
      s1_sgn_q     <= bus.in_data[SER_W-1];
      s1_k_q       <= in_scale[7:2];
      s1_e_q       <= in_scale[ES-1:0];
      s1_frac_q    <= bus.in_data[28:2];
      s1_sat_hi_q  <= s1_sat_hi_d;
      s1_sat_lo_q  <= s1_sat_lo_d;
      s1_inf_q     <= bus.in_data[1];
      s1_zero_q    <= bus.in_data[0];
      s2_valid_q   <= s1_valid_q;
      s2_sgn_q     <= s1_sgn_q;
      s2_body_q    <= word[63:33];
      s2_guard_q   <= word[32];
      s2_sticky_q  <= |word[31:0];
      s2_sat_hi_q  <= s1_sat_hi_q;
      s2_sat_lo_q  <= s1_sat_lo_q;
      s2_inf_q     <= s1_inf_q;
      s2_zero_q    <= s1_zero_q;
      out_valid_q  <= s2_valid_q;
      out_result_q <= res_d;
    end
  end
endmodule
